// File: rtl/multi_synch_edge_detect.sv
// Multi-channel synchroniser, debouncer and registered rise/fall/event pulse generator.
// Optional sticky event capture is enabled by defining STICKY_EVENT_EN.
module multi_synch_edge_detect #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1,
  parameter int RST_LEVEL   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   asynch_in,
  input  logic [2*CHANNELS-1:0] edge_mode,
`ifdef STICKY_EVENT_EN
  input  logic [CHANNELS-1:0]   clr_sticky,
  output logic [CHANNELS-1:0]   evt_sticky,
`endif
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   evt
);

  localparam int                  CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CHANNELS-1:0] RST_VEC  = (RST_LEVEL != 0) ? '1 : '0;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  sync_lvl;
  logic [CNT_W-1:0]                     cnt [CHANNELS];
  logic [CHANNELS-1:0]                  differ;
  logic [CHANNELS-1:0]                  commit;
  logic [CHANNELS-1:0]                  mode_rise;
  logic [CHANNELS-1:0]                  mode_fall;

  // Stage 0 samples the raw pins; only the last stage feeds any logic.
  // NOTE: flops are written with non-blocking assignments so every stage
  // sees the previous cycle's value of its neighbour, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VEC}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], asynch_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign differ   = sync_lvl ^ level_out;

  // NOTE: every always_comb output gets a default before the loop, so no latch
  // can be inferred for a channel or bit the loop might not cover.
  always_comb begin
    commit    = '0;
    mode_rise = '0;
    mode_fall = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      commit[ch]    = differ[ch] && (cnt[ch] == CNT_LAST);
      mode_rise[ch] = edge_mode[2*ch];
      mode_fall[ch] = edge_mode[2*ch+1];
    end
  end

  // A channel commits only after DEB_CYCLES consecutive disagreeing samples;
  // any agreeing sample drops the count back to zero.
  // NOTE: the counter array is tiny, so it is reset like plain flops; a pending
  // change must not survive rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_out <= RST_VEC;
      rise      <= '0;
      fall      <= '0;
      evt       <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (!differ[ch] || commit[ch]) begin
          cnt[ch] <= '0;
        end else begin
          cnt[ch] <= cnt[ch] + CNT_W'(1);
        end
      end
      level_out <= level_out ^ commit;
      rise      <= commit & sync_lvl;
      fall      <= commit & ~sync_lvl;
      evt       <= (commit & sync_lvl & mode_rise) | (commit & ~sync_lvl & mode_fall);
    end
  end

`ifdef STICKY_EVENT_EN
  // Set has priority over clear so an event landing with a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_sticky <= '0;
    end else begin
      evt_sticky <= (evt_sticky & ~clr_sticky) | evt;
    end
  end
`endif

endmodule
